// File: rtl/credit_switch_allocator.sv
// Switch allocator with per-output round-robin arbitration, wormhole locking
// and downstream credit tracking for an N-input, M-output crossbar router.
module credit_switch_allocator #(
  parameter int N       = 4,
  parameter int M       = 4,
  parameter int CREDITS = 20,
  parameter int DW      = $clog2(M),
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  input  logic [N*DW-1:0] req_dst,
  input  logic [N-1:0]    req_tail,
  output logic [N-1:0]    in_pop,
  output logic [M*N-1:0]  xbar_sel,
  output logic [M-1:0]    out_valid,
  input  logic [M-1:0]    credit_in,
  output logic [M*CW-1:0] credit_cnt,
  output logic [M-1:0]    out_locked,
  output logic [M-1:0]    credit_err
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0] sel_vec [M];

  for (genvar gi = 0; gi < M; gi++) begin : g_out
    logic [CW-1:0] cnt_reg;
    logic          lock_reg;
    logic          err_reg;
    logic [PW-1:0] owner_reg;
    logic [PW-1:0] rr_reg;

    logic [N-1:0]  elig;
    logic [N-1:0]  sel;
    logic [PW-1:0] win;
    logic [PW-1:0] idx;
    logic          found;
    logic          grant;

    // A destination >= M can never equal gi, so invalid destinations fall out here.
    always_comb begin
      elig  = '0;
      sel   = '0;
      win   = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
        elig[i] = req_valid[i] && (req_dst[i*DW +: DW] == DW'(gi)) &&
                  (!lock_reg || owner_reg == PW'(i));
      end
      for (int k = 0; k < N; k++) begin
        idx = PW'((int'(rr_reg) + k) % N);
        if (!found && elig[idx]) begin
          found = 1'b1;
          win   = idx;
        end
      end
      grant = rst_n && found && (cnt_reg != '0);
      if (grant) begin
        sel = N'(1) << win;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg   <= CW'(CREDITS);
        lock_reg  <= 1'b0;
        err_reg   <= 1'b0;
        owner_reg <= '0;
        rr_reg    <= '0;
      end else begin
        if (grant) begin
          if (req_tail[win]) begin
            lock_reg <= 1'b0;
            rr_reg   <= PW'((int'(win) + 1) % N);
          end else begin
            lock_reg  <= 1'b1;
            owner_reg <= win;
          end
        end
        // A grant and a returned credit in the same cycle cancel out.
        if (grant && !credit_in[gi]) begin
          cnt_reg <= cnt_reg - CW'(1);
        end else if (!grant && credit_in[gi]) begin
          if (cnt_reg == CW'(CREDITS)) begin
            err_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
      end
    end

    assign sel_vec[gi]             = sel;
    assign xbar_sel[gi*N +: N]     = sel;
    assign out_valid[gi]           = grant;
    assign credit_cnt[gi*CW +: CW] = cnt_reg;
    assign out_locked[gi]          = lock_reg;
    assign credit_err[gi]          = err_reg;
  end

  // Each input targets one output, so at most one select vector has a bit per input.
  always_comb begin
    in_pop = '0;
    for (int o = 0; o < M; o++) begin
      in_pop = in_pop | sel_vec[o];
    end
  end

endmodule
